// File: rtl/axil_master_ctrl.sv
// AXI4-Lite single-beat master driven by a simple command port; AW and W are issued together.
// Define AXIL_TIMEOUT_EN to build the hung-slave watchdog that aborts a stuck transfer.
module axil_master_ctrl #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_write_i,
    input  logic [ADDR_W-1:0]   cmd_addr_i,
    input  logic [DATA_W-1:0]   cmd_wdata_i,
    input  logic [DATA_W/8-1:0] cmd_wstrb_i,
    output logic                done_o,
    output logic [DATA_W-1:0]   done_rdata_o,
    output logic [1:0]          done_resp_o,
    output logic                done_timeout_o,
    output logic [ADDR_W-1:0]   m_axi_lite_awaddr_o,
    output logic                m_axi_lite_awvalid_o,
    input  logic                m_axi_lite_awready_i,
    output logic [DATA_W-1:0]   m_axi_lite_wdata_o,
    output logic [DATA_W/8-1:0] m_axi_lite_wstrb_o,
    output logic                m_axi_lite_wvalid_o,
    input  logic                m_axi_lite_wready_i,
    input  logic [1:0]          m_axi_lite_bresp_i,
    input  logic                m_axi_lite_bvalid_i,
    output logic                m_axi_lite_bready_o,
    output logic [ADDR_W-1:0]   m_axi_lite_araddr_o,
    output logic                m_axi_lite_arvalid_o,
    input  logic                m_axi_lite_arready_i,
    input  logic [DATA_W-1:0]   m_axi_lite_rdata_i,
    input  logic [1:0]          m_axi_lite_rresp_i,
    input  logic                m_axi_lite_rvalid_i,
    output logic                m_axi_lite_rready_o
);

    if ((DATA_W != 32 && DATA_W != 64) || TIMEOUT_CYC < 2) begin : g_bad_param
        $error("axil_master_ctrl: DATA_W must be 32 or 64 and TIMEOUT_CYC at least 2");
    end

    typedef enum logic [5:0] {
        IDLE    = 6'b000001,
        WR_AW_W = 6'b000010,
        WR_RESP = 6'b000100,
        RD_ADDR = 6'b001000,
        RD_DATA = 6'b010000,
        DONE    = 6'b100000
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic                awvalid_q;
    logic                wvalid_q;
    logic                aw_done_q;
    logic                w_done_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [1:0]          resp_q;
    logic                timeout_q;

    logic aw_hs;
    logic w_hs;
    logic tmo_fire;

    assign aw_hs = awvalid_q & m_axi_lite_awready_i;
    assign w_hs  = wvalid_q & m_axi_lite_wready_i;

`ifdef AXIL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             busy;

    assign busy     = (state_q == WR_AW_W) || (state_q == WR_RESP) ||
                      (state_q == RD_ADDR) || (state_q == RD_DATA);
    assign cnt_d    = cnt_q + 1'b1;
    assign tmo_fire = busy && (cnt_d == CNT_W'(TIMEOUT_CYC));

    // Held at zero while idle, so every accepted command starts counting from zero.
    always_ff @(posedge clk_i) begin
        if (rst_i || state_q == IDLE) begin
            cnt_q <= '0;
        end else if (busy) begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign tmo_fire = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= 2'b00;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        addr_q    <= cmd_addr_i;
                        wdata_q   <= cmd_wdata_i;
                        wstrb_q   <= cmd_wstrb_i;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        if (cmd_write_i) begin
                            state_q   <= WR_AW_W;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end else begin
                            state_q <= RD_ADDR;
                        end
                    end
                end
                WR_AW_W: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    // Same-cycle handshakes count here, before the sticky flags update.
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                        state_q <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_axi_lite_bvalid_i) begin
                        resp_q    <= m_axi_lite_bresp_i;
                        timeout_q <= 1'b0;
                        state_q   <= DONE;
                    end
                end
                RD_ADDR: begin
                    if (m_axi_lite_arready_i) begin
                        state_q <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m_axi_lite_rvalid_i) begin
                        rdata_q   <= m_axi_lite_rdata_i;
                        resp_q    <= m_axi_lite_rresp_i;
                        timeout_q <= 1'b0;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q   <= IDLE;
                    awvalid_q <= 1'b0;
                    wvalid_q  <= 1'b0;
                end
            endcase

            // Watchdog abort overrides whatever the current state decided.
            if (tmo_fire) begin
                state_q   <= DONE;
                awvalid_q <= 1'b0;
                wvalid_q  <= 1'b0;
                resp_q    <= 2'b10;
                timeout_q <= 1'b1;
            end
        end
    end

    assign cmd_ready_o          = (state_q == IDLE);
    assign done_o               = (state_q == DONE);
    assign done_rdata_o         = rdata_q;
    assign done_resp_o          = resp_q;
    assign done_timeout_o       = (state_q == DONE) && timeout_q;
    assign m_axi_lite_awaddr_o  = addr_q;
    assign m_axi_lite_awvalid_o = awvalid_q;
    assign m_axi_lite_wdata_o   = wdata_q;
    assign m_axi_lite_wstrb_o   = wstrb_q;
    assign m_axi_lite_wvalid_o  = wvalid_q;
    assign m_axi_lite_bready_o  = (state_q == WR_RESP);
    assign m_axi_lite_araddr_o  = addr_q;
    assign m_axi_lite_arvalid_o = (state_q == RD_ADDR);
    assign m_axi_lite_rready_o  = (state_q == RD_DATA);

endmodule

// File: tb/tb_axil_master_ctrl.sv
// Directed bench for axil_master_ctrl: a cycle-stepped slave model with a small register file.
// The watchdog scenario runs only when AXIL_TIMEOUT_EN is defined.
module tb_axil_master_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [9:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        done, done_timeout;
    logic [31:0] done_rdata;
    logic [1:0]  done_resp;
    logic [9:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int checks = 0;
    int errors = 0;
    logic [31:0] mem [0:255];
    logic [9:0]  lastAwaddr, lastAraddr;
    logic [31:0] lastWdata;
    logic [3:0]  lastWstrb;

    always #5 clk = ~clk;

    axil_master_ctrl #(.ADDR_W(10), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_wstrb_i(cmd_wstrb),
        .done_o(done), .done_rdata_o(done_rdata), .done_resp_o(done_resp),
        .done_timeout_o(done_timeout),
        .m_axi_lite_awaddr_o(awaddr), .m_axi_lite_awvalid_o(awvalid), .m_axi_lite_awready_i(awready),
        .m_axi_lite_wdata_o(wdata), .m_axi_lite_wstrb_o(wstrb), .m_axi_lite_wvalid_o(wvalid),
        .m_axi_lite_wready_i(wready),
        .m_axi_lite_bresp_i(bresp), .m_axi_lite_bvalid_i(bvalid), .m_axi_lite_bready_o(bready),
        .m_axi_lite_araddr_o(araddr), .m_axi_lite_arvalid_o(arvalid), .m_axi_lite_arready_i(arready),
        .m_axi_lite_rdata_i(rdata), .m_axi_lite_rresp_i(rresp), .m_axi_lite_rvalid_i(rvalid),
        .m_axi_lite_rready_o(rready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one command for a single cycle (cycle 0); returns at the start of cycle 1.
    task automatic issue(input logic wr, input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Write-side slave; returns in the cycle after done with all slave inputs low.
    task automatic serveWrite(input int awDly, input int wDly, input logic [1:0] rsp,
                              output int doneCyc, output int nDone, output int awDrop,
                              output int wDrop, output logic earlyBready, output logic readyLow);
        logic awHs, wHs, bHs;
        doneCyc = -1; nDone = 0; awDrop = -1; wDrop = -1;
        earlyBready = 1'b0; readyLow = 1'b1;
        awHs = 1'b0; wHs = 1'b0; bHs = 1'b0;
        bresp = rsp;
        for (int c = 1; c <= 60; c++) begin
            awready = (c >= 1 + awDly);
            wready  = (c >= 1 + wDly);
            bvalid  = !bHs;
            if (done) begin
                nDone++;
                if (doneCyc < 0) doneCyc = c;
            end
            if (cmd_ready && !(doneCyc >= 0 && c > doneCyc)) readyLow = 1'b0;
            if (bready && !(awHs && wHs)) earlyBready = 1'b1;
            if (awvalid && awready && !awHs) begin awHs = 1'b1; lastAwaddr = awaddr; end
            if (wvalid && wready && !wHs) begin wHs = 1'b1; lastWdata = wdata; lastWstrb = wstrb; end
            if (!awvalid && awDrop < 0) awDrop = c;
            if (!wvalid && wDrop < 0) wDrop = c;
            if (bvalid && bready) bHs = 1'b1;
            if (doneCyc >= 0 && c > doneCyc) break;
            tick();
        end
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        if (awHs && wHs) begin
            for (int b = 0; b < 4; b++)
                if (lastWstrb[b]) mem[lastAwaddr[9:2]][8*b +: 8] = lastWdata[8*b +: 8];
        end
        if (doneCyc < 0) begin
            checks++; errors++;
            $display("[TB] FAIL write_budget: no done within 60 cycles");
        end
    endtask

    // Read-side slave; returns in the cycle after done with all slave inputs low.
    task automatic serveRead(input int arDly, input int rDly, input logic [31:0] rd,
                             input logic [1:0] rsp, output int doneCyc, output int nDone);
        int arHsCyc;
        logic rHs;
        doneCyc = -1; nDone = 0; arHsCyc = 0; rHs = 1'b0;
        rdata = rd;
        rresp = rsp;
        for (int c = 1; c <= 60; c++) begin
            arready = (c >= 1 + arDly);
            rvalid  = (arHsCyc > 0) && (c >= arHsCyc + 1 + rDly) && !rHs;
            if (done) begin
                nDone++;
                if (doneCyc < 0) doneCyc = c;
            end
            if (arvalid && arready && arHsCyc == 0) begin arHsCyc = c; lastAraddr = araddr; end
            if (rvalid && rready) rHs = 1'b1;
            if (doneCyc >= 0 && c > doneCyc) break;
            tick();
        end
        arready = 1'b0; rvalid = 1'b0;
        if (doneCyc < 0) begin
            checks++; errors++;
            $display("[TB] FAIL read_budget: no done within 60 cycles");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        checks++; if ({done, done_timeout} !== 2'b00) begin errors++; $display("[TB] FAIL reset_done: got %b expected 00", {done, done_timeout}); end
        checks++; if ({awvalid, wvalid, arvalid, bready, rready} !== 5'b0) begin errors++; $display("[TB] FAIL reset_handshakes: got %b expected 00000", {awvalid, wvalid, arvalid, bready, rready}); end
        checks++; if (done_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 00000000", done_rdata); end
        checks++; if (done_resp !== 2'b00) begin errors++; $display("[TB] FAIL reset_resp: got %b expected 00", done_resp); end
        checks++; if ({awaddr, araddr, wdata, wstrb} !== 56'h0) begin errors++; $display("[TB] FAIL reset_axi_payload: got %h expected 0", {awaddr, araddr, wdata, wstrb}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_zero_wait();
        int dc, nd, awd, wd;
        logic early, rl;
        issue(1'b1, 10'h040, 32'hDEADBEEF, 4'hF);
        serveWrite(0, 0, 2'b00, dc, nd, awd, wd, early, rl);
        checks++; if (dc !== 3) begin errors++; $display("[TB] FAIL zw_write_done_cycle: got %0d expected 3", dc); end
        checks++; if (nd !== 1) begin errors++; $display("[TB] FAIL zw_write_done_count: got %0d expected 1", nd); end
        checks++; if (early !== 1'b0) begin errors++; $display("[TB] FAIL zw_early_bready: got %b expected 0", early); end
        checks++; if (rl !== 1'b1) begin errors++; $display("[TB] FAIL zw_cmd_ready_busy: got %b expected 1 (low while busy)", rl); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL zw_cmd_ready_cycle4: got %b expected 1", cmd_ready); end
        checks++; if (done_resp !== 2'b00) begin errors++; $display("[TB] FAIL zw_write_resp: got %b expected 00", done_resp); end
        checks++; if (lastAwaddr !== 10'h040) begin errors++; $display("[TB] FAIL zw_awaddr: got %h expected 040", lastAwaddr); end
        checks++; if (mem[8'h10] !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL zw_slave_reg: got %h expected deadbeef", mem[8'h10]); end
        issue(1'b0, 10'h040, 32'h0, 4'h0);
        serveRead(0, 0, mem[8'h10], 2'b00, dc, nd);
        checks++; if (dc !== 3) begin errors++; $display("[TB] FAIL zw_read_done_cycle: got %0d expected 3", dc); end
        checks++; if (done_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL zw_read_data: got %h expected deadbeef", done_rdata); end
        checks++; if (lastAraddr !== 10'h040) begin errors++; $display("[TB] FAIL zw_araddr: got %h expected 040", lastAraddr); end
    endtask

    task automatic test_delayed_handshakes();
        int dc, nd, awd, wd;
        logic early, rl;
        issue(1'b1, 10'h008, 32'h0BADF00D, 4'hF);
        serveWrite(5, 0, 2'b00, dc, nd, awd, wd, early, rl);
        checks++; if (wd !== 2) begin errors++; $display("[TB] FAIL slow_aw_wvalid_drop: got cycle %0d expected 2", wd); end
        checks++; if (awd !== 7) begin errors++; $display("[TB] FAIL slow_aw_awvalid_drop: got cycle %0d expected 7", awd); end
        checks++; if (nd !== 1 || dc !== 8) begin errors++; $display("[TB] FAIL slow_aw_done: got %0d pulses at cycle %0d expected 1 at 8", nd, dc); end
        checks++; if (early !== 1'b0) begin errors++; $display("[TB] FAIL slow_aw_early_bready: got %b expected 0", early); end
        checks++; if (mem[8'h02] !== 32'h0BADF00D) begin errors++; $display("[TB] FAIL slow_aw_reg: got %h expected 0badf00d", mem[8'h02]); end
        issue(1'b1, 10'h00C, 32'h11223344, 4'hF);
        serveWrite(0, 3, 2'b00, dc, nd, awd, wd, early, rl);
        checks++; if (awd !== 2 || wd !== 5) begin errors++; $display("[TB] FAIL slow_w_drops: got aw %0d w %0d expected aw 2 w 5", awd, wd); end
        checks++; if (nd !== 1 || dc !== 6) begin errors++; $display("[TB] FAIL slow_w_done: got %0d pulses at cycle %0d expected 1 at 6", nd, dc); end
        checks++; if (mem[8'h03] !== 32'h11223344) begin errors++; $display("[TB] FAIL slow_w_reg: got %h expected 11223344", mem[8'h03]); end
    endtask

    task automatic test_strobe();
        int dc, nd, awd, wd;
        logic early, rl;
        mem[8'h20] = 32'hAAAAAAAA;
        issue(1'b1, 10'h080, 32'h12345678, 4'b0011);
        serveWrite(0, 0, 2'b01, dc, nd, awd, wd, early, rl);
        checks++; if (lastWstrb !== 4'b0011) begin errors++; $display("[TB] FAIL strb_wstrb: got %b expected 0011", lastWstrb); end
        checks++; if (done_resp !== 2'b01) begin errors++; $display("[TB] FAIL strb_bresp_pass: got %b expected 01", done_resp); end
        checks++; if (done_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL strb_rdata_held: got %h expected deadbeef", done_rdata); end
        issue(1'b0, 10'h080, 32'h0, 4'h0);
        serveRead(0, 0, mem[8'h20], 2'b00, dc, nd);
        checks++; if (done_rdata !== 32'hAAAA5678) begin errors++; $display("[TB] FAIL strb_readback: got %h expected aaaa5678", done_rdata); end
    endtask

    task automatic test_read_error();
        int dc, nd;
        issue(1'b0, 10'h3FC, 32'h0, 4'h0);
        serveRead(0, 3, 32'hCAFEF00D, 2'b10, dc, nd);
        checks++; if (nd !== 1 || dc !== 6) begin errors++; $display("[TB] FAIL rderr_done: got %0d pulses at cycle %0d expected 1 at 6", nd, dc); end
        checks++; if (done_rdata !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL rderr_data: got %h expected cafef00d", done_rdata); end
        checks++; if (done_resp !== 2'b10) begin errors++; $display("[TB] FAIL rderr_resp: got %b expected 10", done_resp); end
        checks++; if (lastAraddr !== 10'h3FC) begin errors++; $display("[TB] FAIL rderr_araddr: got %h expected 3fc", lastAraddr); end
        checks++; if (done_timeout !== 1'b0) begin errors++; $display("[TB] FAIL rderr_timeout: got %b expected 0", done_timeout); end
    endtask

    task automatic test_reset_mid_write();
        int dc, nd, extra;
        issue(1'b1, 10'h044, 32'h55555555, 4'hF);
        awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
        tick();
        awready = 1'b0; wready = 1'b0;
        checks++; if (bready !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_in_wr_resp: bready got %b expected 1", bready); end
        tick();
        rst = 1'b1;
        tick();
        checks++; if ({awvalid, wvalid, arvalid, bready, rready} !== 5'b0) begin errors++; $display("[TB] FAIL rstmid_handshakes: got %b expected 00000", {awvalid, wvalid, arvalid, bready, rready}); end
        checks++; if (cmd_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_status: got ready %b done %b expected 1 0", cmd_ready, done); end
        checks++; if (done_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_rdata_cleared: got %h expected 0", done_rdata); end
        rst = 1'b0;
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL rstmid_no_done: got %0d pulses expected 0", extra); end
        issue(1'b0, 10'h040, 32'h0, 4'h0);
        serveRead(0, 0, mem[8'h10], 2'b00, dc, nd);
        checks++; if (dc !== 3 || done_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL rstmid_next_cmd: got cycle %0d data %h expected 3 deadbeef", dc, done_rdata); end
    endtask

    task automatic test_ignore_cmd();
        int dc, nd;
        issue(1'b0, 10'h040, 32'h0, 4'h0);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h100; cmd_wdata = 32'hFFFFFFFF; cmd_wstrb = 4'hF;
        arready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (arvalid !== 1'b1 || awvalid !== 1'b0 || araddr !== 10'h040 || cmd_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL ignore_cmd: got arvalid %b awvalid %b araddr %h ready %b expected 1 0 040 0", arvalid, awvalid, araddr, cmd_ready);
            end
            tick();
        end
        cmd_valid = 1'b0;
        serveRead(0, 0, mem[8'h10], 2'b00, dc, nd);
        checks++; if (nd !== 1 || done_rdata !== 32'hDEADBEEF || lastAraddr !== 10'h040) begin errors++; $display("[TB] FAIL ignore_cmd_result: got %0d pulses data %h addr %h expected 1 deadbeef 040", nd, done_rdata, lastAraddr); end
        checks++; if (awvalid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL ignore_cmd_idle: got awvalid %b ready %b expected 0 1", awvalid, cmd_ready); end
    endtask

    task automatic test_back_to_back();
        int dc, nd, awd, wd;
        logic early, rl;
        issue(1'b1, 10'h0C8, 32'h600DCAFE, 4'hF);
        serveWrite(0, 0, 2'b00, dc, nd, awd, wd, early, rl);
        issue(1'b0, 10'h0C8, 32'h0, 4'h0);
        serveRead(0, 0, mem[8'h32], 2'b00, dc, nd);
        checks++; if (dc !== 3 || done_rdata !== 32'h600DCAFE) begin errors++; $display("[TB] FAIL b2b_read: got cycle %0d data %h expected 3 600dcafe", dc, done_rdata); end
    endtask

`ifdef AXIL_TIMEOUT_EN
    task automatic test_timeout();
        int dc;
        logic tmo;
        logic [1:0] rsp;
        dc = -1; tmo = 1'b0; rsp = 2'b00;
        issue(1'b1, 10'h010, 32'h1, 4'hF);
        awready = 1'b0; wready = 1'b1;
        for (int c = 1; c <= 40 && dc < 0; c++) begin
            if (done) begin dc = c; tmo = done_timeout; rsp = done_resp; end
            else tick();
        end
        wready = 1'b0;
        checks++; if (dc !== 17) begin errors++; $display("[TB] FAIL tmo_done_cycle: got %0d expected 17", dc); end
        checks++; if (tmo !== 1'b1 || rsp !== 2'b10) begin errors++; $display("[TB] FAIL tmo_status: got timeout %b resp %b expected 1 10", tmo, rsp); end
        tick();
        checks++; if (awvalid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL tmo_idle: got awvalid %b ready %b expected 0 1", awvalid, cmd_ready); end
    endtask
`endif

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        test_reset();
        test_zero_wait();
        test_delayed_handshakes();
        test_strobe();
        test_read_error();
        test_reset_mid_write();
        test_ignore_cmd();
        test_back_to_back();
`ifdef AXIL_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axil_master_ctrl.md
# axil_master_ctrl

Parametrised AXI4-Lite master that executes single-beat register reads and writes issued on a simple command port. It sits between the DMA control logic and the AXI-Lite register interface of the downstream IP. It drives AW and W concurrently, supports byte strobes and reads, and returns the slave response with a one-cycle completion pulse.

## Interface
- `ADDR_W`, default 10: address width of `cmd_addr` and of AW/AR.
- `DATA_W`, default 32: data width; must be 32 or 64.
- `TIMEOUT_CYC`, default 1024: watchdog limit in cycles; used only when `AXIL_TIMEOUT_EN` is defined.
- `clk` input 1: single clock; every register changes on its rising edge.
- `rst` input 1: synchronous reset, active-high.
- `cmd_valid` input 1: command request.
- `cmd_ready` output 1: high only in IDLE.
- `cmd_write` input 1: 1 = write, 0 = read.
- `cmd_addr` input ADDR_W: target address.
- `cmd_wdata` input DATA_W: write data.
- `cmd_wstrb` input DATA_W/8: write byte strobes.
- `done` output 1: one-cycle completion pulse.
- `done_rdata` output DATA_W: read data; holds until the next `done`.
- `done_resp` output 2: BRESP or RRESP of the finished transfer.
- `done_timeout` output 1: high together with `done` when the watchdog fired.
- `m_axi_lite_awaddr/awvalid/awready`: AW channel; widths ADDR_W, 1, 1.
- `m_axi_lite_wdata/wstrb/wvalid/wready`: W channel; widths DATA_W, DATA_W/8, 1, 1.
- `m_axi_lite_bresp/bvalid/bready`: B channel; widths 2, 1, 1.
- `m_axi_lite_araddr/arvalid/arready`: AR channel; widths ADDR_W, 1, 1.
- `m_axi_lite_rdata/rresp/rvalid/rready`: R channel; widths DATA_W, 2, 1, 1.
- `awprot`/`arprot` are not ports. The integration level ties them to 3'b000.

## Operation
- **States:** IDLE, WR_AW_W, WR_RESP, RD_ADDR, RD_DATA, DONE. Use one-hot encoding. Unknown encodings go to IDLE.
- **IDLE:** when `cmd_valid & cmd_ready`, latch addr, wdata and wstrb into registers. Go to WR_AW_W if `cmd_write`, otherwise RD_ADDR.
- **WR_AW_W:**
  - `awvalid` and `wvalid` both assert on entry.
  - Each valid drops the cycle after its own handshake.
  - Sticky flags `aw_done` and `w_done` record each handshake.
  - When both flags are set, go to WR_RESP. This includes the case where both handshakes happen in the same cycle.
  - AW and W may complete in either order.
- **WR_RESP:** `bready` is 1. On `bvalid`, capture `bresp` into `done_resp` and go to DONE.
- **RD_ADDR:** `arvalid` is 1. On `arready`, go to RD_DATA.
- **RD_DATA:** `rready` is 1. On `rvalid`, capture `rdata` and `rresp`, then go to DONE.
- **DONE:** `done` is 1 for exactly one cycle, then go to IDLE.
- **Invariants:**
  - A valid never deasserts before its handshake, except on watchdog abort.
  - Address and data are stable while valid is high.
  - `cmd_*` inputs are ignored outside IDLE.
  - A non-OKAY response is passed through and does not cause a retry.
- **Reset mid-transfer:** all valids drop the next cycle, the FSM returns to IDLE, and no `done` is issued.

## Timing
- **Reset values:**
  - `cmd_ready` = 1.
  - `done`, `done_timeout` = 0.
  - All valid and ready outputs = 0.
  - `done_rdata` = 0, `done_resp` = 2'b00.
  - AXI address, data and strobe outputs = 0.
- All AXI and status outputs are registered or decoded from state. There are no combinational paths from AXI inputs to AXI outputs.
- Command accepted at cycle 0 → `awvalid`/`wvalid` (or `arvalid`) high at cycle 1.
- **Write with zero-wait slave** (awready, wready and bvalid already high): both handshakes at cycle 1, bready at cycle 2, B handshake at cycle 2, `done` at cycle 3, `cmd_ready` back high at cycle 4.
- **Read with zero-wait slave:** AR handshake at cycle 1, R handshake at cycle 2, `done` at cycle 3.
- A `bvalid` that arrives before WR_RESP is not accepted; `bready` stays 0 until WR_RESP.
- `done_rdata` updates only on read completion. Writes leave it unchanged.

## Configuration
- **`AXIL_TIMEOUT_EN` defined:**
  - A counter of width $clog2(TIMEOUT_CYC)+1 clears on command acceptance and increments in every non-IDLE, non-DONE state.
  - When it reaches TIMEOUT_CYC, all valids and readies drop the next cycle and the FSM enters DONE.
  - DONE then reports `done_timeout` = 1 and `done_resp` = 2'b10.
  - This abort is a debug escape for hung slaves and is a deliberate AXI rule break.
- **`AXIL_TIMEOUT_EN` not defined:** no counter is built, `done_timeout` is tied to 0, and the master waits indefinitely.

## Test plan
- Write addr 0x040, data 0xDEADBEEF, wstrb 4'hF, zero-wait slave → `done` at cycle 3, `done_resp`=00, slave reg = 0xDEADBEEF.
- Write where awready is delayed 5 cycles and wready is immediate → wvalid drops at cycle 2, awvalid holds until cycle 6, a single `done`, data correct.
- Write wstrb 4'b0011, data 0x12345678 to a reg holding 0xAAAAAAAA → reg reads back 0xAAAA5678.
- Read addr 0x3FC with a slave returning 0xCAFEF00D and rresp 2'b10, rvalid delayed 3 cycles → `done_rdata`=0xCAFEF00D, `done_resp`=10.
- `rst` pulsed while in WR_RESP → valids and readies 0 next cycle, no `done`, `cmd_ready`=1, next command completes normally.
- `AXIL_TIMEOUT_EN` with TIMEOUT_CYC=16 and a slave that never raises awready → at cycle 17 after accept `done`=1, `done_timeout`=1, `done_resp`=10.
